// File: rtl/rptr_empty_lvl.sv
// Read-side pointer, empty flag, fill level and almost-empty flag for the async FIFO (rclk domain).
// Optional sticky underflow flag and its clear input are enabled by defining RPTR_UNDERFLOW_EN.
module rptr_empty_lvl #(
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
`ifdef RPTR_UNDERFLOW_EN
  input  logic                rerr_clr,
  output logic                runderflow,
`endif
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel
);

  localparam logic [ADDRSIZE:0] DEPTH  = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [ADDRSIZE:0] AE_LVL = (ADDRSIZE+1)'(AE_THRESH);

  logic              rpop;
  logic [ADDRSIZE:0] rbin_reg;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic [ADDRSIZE:0] rwbin;
  logic [ADDRSIZE:0] level_raw;
  logic [ADDRSIZE:0] level_next;

  assign rpop       = rinc & ~rempty;
  assign rbin_next  = rbin_reg + {{ADDRSIZE{1'b0}}, rpop};
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign raddr      = rbin_reg[ADDRSIZE-1:0];

  // Each binary bit is the XOR of all Gray bits at and above it.
  generate
    for (genvar gi = 0; gi <= ADDRSIZE; gi++) begin : g_g2b
      assign rwbin[gi] = ^rq2_wptr[ADDRSIZE:gi];
    end
  endgenerate

  // Keeping the wrap bit makes the subtraction correct across pointer wrap.
  assign level_raw  = rwbin - rbin_next;
  assign level_next = (level_raw > DEPTH) ? DEPTH : level_raw;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_reg      <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      ralmost_empty <= 1'b1;
      rlevel        <= '0;
    end else begin
      rbin_reg      <= rbin_next;
      rptr          <= rgray_next;
      rempty        <= (rgray_next == rq2_wptr);
      ralmost_empty <= (level_next <= AE_LVL);
      rlevel        <= level_next;
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      runderflow <= 1'b0;
    end else if (rinc & rempty) begin
      runderflow <= 1'b1;
    end else if (rerr_clr) begin
      runderflow <= 1'b0;
    end
  end
`endif

endmodule
